// File: rtl/seq_detect_param.sv
// seq_detect_param: serial bit-pattern detector.
// Compares the last WIDTH accepted bits of x (oldest in the MSB) against
// PATTERN and flags each match on y. Matches may share bits (OVERLAP=1) or
// restart the history after each match (OVERLAP=0). y is combinational
// (MEALY=1) or registered one cycle later (MEALY=0).
// Optional feature macro: SEQDET_COUNTER_EN builds the saturating match
// counter; without it count and sat are tied to zero.
module seq_detect_param #(
    parameter int unsigned             WIDTH   = 3,
    parameter logic [WIDTH-1:0]        PATTERN = {WIDTH{1'b1}},
    parameter int unsigned             OVERLAP = 1,
    parameter int unsigned             MEALY   = 1,
    parameter int unsigned             CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic             x,
    output logic             y,
    output logic [CNT_W-1:0] count,
    output logic             sat
);

    localparam int unsigned    FW       = $clog2(WIDTH);
    localparam logic [FW-1:0]  FILL_MAX = FW'(WIDTH - 1);

    logic [WIDTH-2:0] hist_q, hist_d;
    logic [FW-1:0]    fill_q, fill_d;
    logic [WIDTH-1:0] window;
    logic             accepted;
    logic             full;
    logic             hit;

    // clr wins over en, so a completing bit under clr never counts as a hit.
    assign accepted = en & ~clr;
    assign full     = (fill_q == FILL_MAX);
    assign window   = {hist_q, x};
    assign hit      = accepted & full & (window == PATTERN);

    // Next history/fill: restart on clr or on a non-overlapping hit,
    // otherwise shift in the accepted bit; idle cycles are invisible.
    always_comb begin
        hist_d = hist_q;
        fill_d = fill_q;
        if (clr) begin
            hist_d = '0;
            fill_d = '0;
        end else if (accepted) begin
            if (hit && (OVERLAP == 0)) begin
                hist_d = '0;
                fill_d = '0;
            end else begin
                hist_d = window[WIDTH-2:0];
                fill_d = full ? fill_q : fill_q + 1'b1;
            end
        end
    end

    // History and fill registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_q <= '0;
            fill_q <= '0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
        end
    end

    generate
        if (MEALY != 0) begin : g_mealy
            assign y = hit;
        end else begin : g_moore
            logic y_q;
            // Registered match pulse, high the cycle after the completing bit.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    y_q <= 1'b0;
                end else begin
                    y_q <= hit;
                end
            end
            assign y = y_q;
        end
    endgenerate

`ifdef SEQDET_COUNTER_EN
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Saturating match count; clr has priority over any hit.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (hit && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count = cnt_q;
    assign sat   = (cnt_q == CNT_MAX);
`else
    assign count = '0;
    assign sat   = 1'b0;
`endif

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed bench for seq_detect_param. Several configurations share one
// stimulus stream; each configuration is checked against hand-derived values.
module tb_seq_detect_param;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clr = 1'b0;
    logic en  = 1'b0;
    logic x   = 1'b0;

    logic       y_ov, y_nov, y_pm, y_pr, y_c2;
    logic [7:0] cnt_ov, cnt_nov, cnt_pm, cnt_pr;
    logic [1:0] cnt_c2;
    logic       sat_ov, sat_nov, sat_pm, sat_pr, sat_c2;

    // values captured mid-cycle, before the edge that consumes the sample
    logic ym_ov, ym_nov, ym_pm, ym_pr, ym_c2;

    int n_tests = 0;
    int n_fail  = 0;
    int hits_ov;

    always #5 clk = ~clk;

    seq_detect_param #(.WIDTH(3), .PATTERN(3'b111), .OVERLAP(1), .MEALY(1), .CNT_W(8)) u_ov (
        .clk(clk), .rst(rst), .clr(clr), .en(en), .x(x), .y(y_ov), .count(cnt_ov), .sat(sat_ov));
    seq_detect_param #(.WIDTH(3), .PATTERN(3'b111), .OVERLAP(0), .MEALY(1), .CNT_W(8)) u_nov (
        .clk(clk), .rst(rst), .clr(clr), .en(en), .x(x), .y(y_nov), .count(cnt_nov), .sat(sat_nov));
    seq_detect_param #(.WIDTH(3), .PATTERN(3'b101), .OVERLAP(1), .MEALY(1), .CNT_W(8)) u_pm (
        .clk(clk), .rst(rst), .clr(clr), .en(en), .x(x), .y(y_pm), .count(cnt_pm), .sat(sat_pm));
    seq_detect_param #(.WIDTH(3), .PATTERN(3'b101), .OVERLAP(1), .MEALY(0), .CNT_W(8)) u_pr (
        .clk(clk), .rst(rst), .clr(clr), .en(en), .x(x), .y(y_pr), .count(cnt_pr), .sat(sat_pr));
    seq_detect_param #(.WIDTH(3), .PATTERN(3'b111), .OVERLAP(1), .MEALY(1), .CNT_W(2)) u_c2 (
        .clk(clk), .rst(rst), .clr(clr), .en(en), .x(x), .y(y_c2), .count(cnt_c2), .sat(sat_c2));

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // expected count/sat given the number of hits and the counter maximum
    function automatic int exp_cnt(input int hits, input int maxv);
`ifdef SEQDET_COUNTER_EN
        return (hits > maxv) ? maxv : hits;
`else
        return 0;
`endif
    endfunction

    function automatic int exp_sat(input int hits, input int maxv);
`ifdef SEQDET_COUNTER_EN
        return (hits >= maxv) ? 1 : 0;
`else
        return 0;
`endif
    endfunction

    // Entered at posedge+1; asserts rst asynchronously and checks the reset state.
    task automatic do_reset();
        rst = 1'b1; en = 1'b0; x = 1'b0; clr = 1'b0;
        #3;
        check("rst_cnt_ov", cnt_ov, 0);
        check("rst_sat_ov", sat_ov, 0);
        check("rst_y_pr",   y_pr,   0);
        check("rst_y_ov",   y_ov,   0);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // One cycle: drive at posedge+1, capture combinational outputs, pass the edge.
    task automatic cyc(input logic e, input logic xx, input logic c);
        en = e; x = xx; clr = c;
        #2;
        ym_ov = y_ov; ym_nov = y_nov; ym_pm = y_pm; ym_pr = y_pr; ym_c2 = y_c2;
        @(posedge clk);
        #1;
    endtask

    bit e1_ov  [8] = '{0, 0, 1, 1, 1, 1, 1, 1};
    bit e1_nov [8] = '{0, 0, 1, 0, 0, 1, 0, 0};
    bit e2_x   [5] = '{1, 0, 1, 0, 1};
    bit e2_hit [5] = '{0, 0, 1, 0, 1};

    initial begin
        @(posedge clk);
        #1;

        // all-ones stream: overlapping vs non-overlapping, counter saturation
        do_reset();
        hits_ov = 0;
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, 1'b1, 1'b0);
            hits_ov += e1_ov[i];
            check($sformatf("ones_ov_y%0d", i + 1),  ym_ov,  e1_ov[i]);
            check($sformatf("ones_nov_y%0d", i + 1), ym_nov, e1_nov[i]);
            check($sformatf("ones_ov_cnt%0d", i + 1), cnt_ov, exp_cnt(hits_ov, 255));
            check($sformatf("ones_c2_cnt%0d", i + 1), cnt_c2, exp_cnt(hits_ov, 3));
            check($sformatf("ones_c2_sat%0d", i + 1), sat_c2, exp_sat(hits_ov, 3));
        end
        check("ones_nov_cnt", cnt_nov, exp_cnt(2, 255));

        // clr on a completing bit: no pulse, everything cleared
        cyc(1'b1, 1'b1, 1'b1);
        check("clr_y_ov",   ym_ov,  0);
        check("clr_y_c2",   ym_c2,  0);
        check("clr_cnt_ov", cnt_ov, 0);
        check("clr_cnt_c2", cnt_c2, 0);
        check("clr_sat_c2", sat_c2, 0);
        cyc(1'b1, 1'b1, 1'b0);
        check("postclr_y1", ym_ov, 0);
        cyc(1'b1, 1'b1, 1'b0);
        check("postclr_y2", ym_ov, 0);
        cyc(1'b1, 1'b1, 1'b0);
        check("postclr_y3", ym_ov, 1);
        check("postclr_cnt", cnt_ov, exp_cnt(1, 255));
        // en low with a full all-ones history: no hit, count holds
        cyc(1'b0, 1'b1, 1'b0);
        check("idle_y",   ym_ov,  0);
        check("idle_cnt", cnt_ov, exp_cnt(1, 255));

        // 101 pattern, Mealy and registered outputs
        do_reset();
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, e2_x[i], 1'b0);
            check($sformatf("p101_m_y%0d", i + 1), ym_pm, e2_hit[i]);
            check($sformatf("p101_r_pre%0d", i + 1), ym_pr, (i > 0) ? e2_hit[i-1] : 1'b0);
            check($sformatf("p101_r_post%0d", i + 1), y_pr, e2_hit[i]);
            check($sformatf("p101_ov_y%0d", i + 1), ym_ov, 0);
        end
        check("p101_cnt", cnt_pm, exp_cnt(2, 255));

        // en gap stretches the window
        do_reset();
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        check("gap_idle_y", ym_ov, 0);
        cyc(1'b1, 1'b1, 1'b0);
        check("gap_hit_y", ym_ov, 1);

        // reset mid-run discards partial history
        do_reset();
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        do_reset();
        cyc(1'b1, 1'b1, 1'b0);
        check("midrst_y1", ym_ov, 0);
        cyc(1'b1, 1'b1, 1'b0);
        check("midrst_y2", ym_ov, 0);
        cyc(1'b1, 1'b1, 1'b0);
        check("midrst_y3", ym_ov, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_detect_param.md
# seq_detect_param

Parametrised serial bit-pattern detector: compares the last WIDTH accepted bits of a serial input against a fixed pattern and flags each match. Supports overlapping and non-overlapping match modes and Mealy (same-cycle) or Moore (registered) output. An optional saturating match counter can be compiled in. It is the general successor to the team's fixed-state run-of-ones detectors and sits directly on a serial data line inside a larger controller.

## Interface
- WIDTH, 3, pattern length in bits; legal range 2..16
- PATTERN, 3'b111, WIDTH-bit pattern; MSB is the oldest bit, LSB the newest
- OVERLAP, 1, 1 = matches may share bits; 0 = history restarts after each match
- MEALY, 1, 1 = y is combinational from the current x; 0 = y is registered, one cycle later
- CNT_W, 8, match counter width; legal range 1..32

- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- clr  in  1  synchronous restart: clears history, fill and counter
- en   in  1  sample qualifier; x is accepted only when en=1
- x    in  1  serial data bit
- y    out  1  match pulse
- count  out  CNT_W  number of matches since reset/clr (saturating)
- sat  out  1  count is at its maximum, 2^CNT_W-1

## Operation
- State: hist (WIDTH-1 bits, previously accepted bits) and fill (0..WIDTH-1, number of valid history bits).
- Accepted sample: en=1 and clr=0.
- hit = accepted & (fill == WIDTH-1) & ({hist, x} == PATTERN).
- On an accepted sample with hit=1 and OVERLAP=0: hist <= 0, fill <= 0.
- On any other accepted sample: x is shifted into the LSB of hist and the oldest bit is dropped; fill <= min(fill+1, WIDTH-1).
- en=0 and clr=0: hist, fill and count hold; hit=0.
- clr=1: hist, fill and count become 0 on the next edge, regardless of en. clr takes priority over en, so hit=0 while clr=1.
- Output y:
  - MEALY=1: y = hit.
  - MEALY=0: y <= hit on every edge.
- Counter: on hit, count <= count+1 unless count is already max, in which case it holds. sat = (count == max).
- Reset (rst=1, asynchronous): hist=0, fill=0, count=0. Registered y=0; sat=0; Mealy y=0 because fill=0.
- Reset mid-run discards any partial history. A match requires WIDTH fresh accepted bits after rst is released.

## Timing
- MEALY=1: y rises in the same cycle as the completing bit on x, with zero latency; it is combinational from x, en and clr.
- MEALY=0: y is high during the cycle after the completing sample; there is no combinational path from input to output.
- count updates on the same edge that samples the hit; the new value is visible the cycle after the hit.
- The first possible hit is on the WIDTH-th accepted sample after reset or clr.
- With OVERLAP=1, back-to-back hits are possible on every accepted cycle (e.g. a pattern of all ones).
- With OVERLAP=0, the minimum spacing between hits is WIDTH accepted samples.
- en gaps stretch the window without breaking it: non-accepted cycles are invisible to the detector.

## Configuration
- Macro SEQDET_COUNTER_EN.
- Defined: the counter and the sat logic are built as described above.
- Undefined: no counter registers are built; count is tied to 0 and sat is tied to 0. Detection and y are unchanged.

## Test plan
- WIDTH=3, PATTERN=111, OVERLAP=1, MEALY=1; x=1 for 5 consecutive accepted cycles -> y=1 on samples 3, 4 and 5, coincident with x; count=3.
- Same stimulus with OVERLAP=0 -> y=1 on sample 3 only; count=1. Continuing x=1 gives the next hit on sample 6.
- PATTERN=101, OVERLAP=1; x sequence 1,0,1,0,1 -> hits on samples 3 and 5. With MEALY=0, y is high in the cycle following each of those samples.
- Bits 1,1 (en=1), then one cycle with en=0, x=0, then 1 (en=1), PATTERN=111 -> one hit on the third accepted bit. rst pulsed after the first two 1s instead -> no hit.
- CNT_W=2, OVERLAP=1, 6 consecutive hits -> count goes 1,2,3 and then holds at 3; sat=1 from the third hit on. clr=1 for one cycle -> count=0 and sat=0. clr asserted on a completing bit -> y=0 and no increment.
- Build with SEQDET_COUNTER_EN undefined -> count=0 and sat=0 at all times, and the y waveform is identical to the defined build.
